// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock, LSB chunk first,
// ripple carry held in a register, valid/ready on both operand and result sides.
module addsub_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK:0]    sum;
    logic              last_chunk;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
        sum        = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        last_chunk = (cnt_q == CW'(NCHUNK - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                // B is stored pre-inverted and carry seeded with sub, so CALC only ever adds.
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (cnt_q == CW'(i)) begin
                        res_d[i*CHUNK +: CHUNK] = sum[CHUNK-1:0];
                    end
                end
                carry_d = sum[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (last_chunk) begin
                    state_d = DONE;
                    cout_d  = sum[CHUNK];
                    zero_d  = (res_d == '0);
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (res_d[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign carryout  = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq: 8/4, 16/4 and 8/8 configurations, directed vectors.
module tb_addsub_seq;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        o;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];
    exp_t cur0, cur1, cur2;
    logic p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;

    logic        iv0, ir0, s0, ov0, or0, c0, o0, z0;
    logic [7:0]  a0, b0, r0;
    logic        iv1, ir1, s1, ov1, or1, c1, o1, z1;
    logic [15:0] a1, b1, r1;
    logic        iv2, ir2, s2, ov2, or2, c2, o2, z2;
    logic [7:0]  a2, b2, r2;

    addsub_seq #(.WIDTH(8), .CHUNK(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .sub(s0),
        .out_valid(ov0), .out_ready(or0), .result(r0), .carryout(c0), .overflow(o0), .zero(z0));
    addsub_seq #(.WIDTH(16), .CHUNK(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .sub(s1),
        .out_valid(ov1), .out_ready(or1), .result(r1), .carryout(c1), .overflow(o1), .zero(z1));
    addsub_seq #(.WIDTH(8), .CHUNK(8)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .sub(s2),
        .out_valid(ov2), .out_ready(or2), .result(r2), .carryout(c2), .overflow(o2), .zero(z2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic mon_first(input string nm, input exp_t e, input logic [15:0] r,
                             input logic c, input logic o, input logic z, input int lat);
        chk({nm, "_result"},   32'(r), 32'(e.res));
        chk({nm, "_carryout"}, 32'(c), 32'(e.c));
        chk({nm, "_overflow"}, 32'(o), 32'(e.o));
        chk({nm, "_zero"},     32'(z), 32'(e.z));
        chk({nm, "_latency"},  32'(lat), 32'(e.lat));
    endtask

    task automatic mon_hold(input string nm, input exp_t e, input logic [15:0] r,
                            input logic c, input logic o, input logic z, input logic ir);
        chk({nm, "_hold_result"},   32'(r), 32'(e.res));
        chk({nm, "_hold_carryout"}, 32'(c), 32'(e.c));
        chk({nm, "_hold_overflow"}, 32'(o), 32'(e.o));
        chk({nm, "_hold_zero"},     32'(z), 32'(e.z));
        chk({nm, "_hold_in_ready"}, 32'(ir), 32'(0));
    endtask

    task automatic unexpected(input string nm);
        checks++;
        failures++;
        $display("FAIL %s_unexpected_out_valid actual=1 required=0 (t=%0t)", nm, $time);
    endtask

    // Monitors: compare on the first out_valid cycle, then check the result is held.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst_n && ov0 && !p0) begin
            if (sb0.size() == 0) unexpected("u0");
            else begin
                e = sb0.pop_front();
                cur0 <= e;
                mon_first("u0", e, {8'h00, r0}, c0, o0, z0, cyc - e.acc - 1);
            end
        end else if (rst_n && ov0 && p0) begin
            mon_hold("u0", cur0, {8'h00, r0}, c0, o0, z0, ir0);
        end
        p0 <= ov0;
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n && ov1 && !p1) begin
            if (sb1.size() == 0) unexpected("u1");
            else begin
                e = sb1.pop_front();
                cur1 <= e;
                mon_first("u1", e, r1, c1, o1, z1, cyc - e.acc - 1);
            end
        end else if (rst_n && ov1 && p1) begin
            mon_hold("u1", cur1, r1, c1, o1, z1, ir1);
        end
        p1 <= ov1;
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst_n && ov2 && !p2) begin
            if (sb2.size() == 0) unexpected("u2");
            else begin
                e = sb2.pop_front();
                cur2 <= e;
                mon_first("u2", e, {8'h00, r2}, c2, o2, z2, cyc - e.acc - 1);
            end
        end else if (rst_n && ov2 && p2) begin
            mon_hold("u2", cur2, {8'h00, r2}, c2, o2, z2, ir2);
        end
        p2 <= ov2;
    end

    function automatic logic rdy(input int id);
        case (id)
            0:       return ir0;
            1:       return ir1;
            default: return ir2;
        endcase
    endfunction

    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] er, input logic ec, input logic eo, input logic ez,
                         input int lat);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!rdy(id) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout_u%0d in_ready actual=0 required=1", id);
            return;
        end
        e.res = er; e.c = ec; e.o = eo; e.z = ez; e.lat = lat; e.acc = cyc;
        case (id)
            0: begin a0 = a[7:0]; b0 = b[7:0]; s0 = s; iv0 = 1'b1; sb0.push_back(e); end
            1: begin a1 = a;      b1 = b;      s1 = s; iv1 = 1'b1; sb1.push_back(e); end
            default: begin a2 = a[7:0]; b2 = b[7:0]; s2 = s; iv2 = 1'b1; sb2.push_back(e); end
        endcase
        @(posedge clk);
        #1;
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0 || sb2.size() != 0 || ov0 || ov1 || ov2)
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending actual=%0d required=0",
                     sb0.size() + sb1.size() + sb2.size());
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        iv0 = 0; iv1 = 0; iv2 = 0; s0 = 0; s1 = 0; s2 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; a2 = 0; b2 = 0;
        or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(ir0), 0);
        chk("rst_out_valid", 32'(ov0), 0);
        chk("rst_result", 32'(r0), 0);
        chk("rst_flags", {29'd0, c0, o0, z0}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(ir0), 1);

        issue(0, 16'd27,  16'd5,   1'b0, 16'd32,  1'b0, 1'b0, 1'b0, 2);
        issue(0, 16'd16,  16'd34,  1'b1, 16'd238, 1'b0, 1'b0, 1'b0, 2);
        issue(0, 16'd196, 16'd2,   1'b1, 16'd194, 1'b1, 1'b0, 1'b0, 2);
        issue(0, 16'd100, 16'd100, 1'b0, 16'd200, 1'b0, 1'b1, 1'b0, 2);
        issue(0, 16'd78,  16'd255, 1'b0, 16'd77,  1'b1, 1'b0, 1'b0, 2);
        issue(0, 16'd48,  16'd48,  1'b1, 16'd0,   1'b1, 1'b0, 1'b1, 2);
        drain();

        // Backpressure, with operand inputs scrambled while the operation is in flight.
        or0 = 1'b0;
        issue(0, 16'd100, 16'd27, 1'b1, 16'd73, 1'b1, 1'b0, 1'b0, 2);
        a0 = 8'hFF; b0 = 8'hFF; s0 = 1'b0;
        n = 0;
        while (!ov0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", 32'(ov0), 1);
        repeat (5) @(negedge clk);
        or0 = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", 32'(ov0), 0);
        chk("bp_release_in_ready", 32'(ir0), 1);

        // Reset during CALC discards the operation.
        a0 = 8'd1; b0 = 8'd2; s0 = 1'b0; iv0 = 1'b1;
        @(posedge clk);
        #1 iv0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(ir0), 0);
        chk("midrst_out_valid", 32'(ov0), 0);
        chk("midrst_result", 32'(r0), 0);
        chk("midrst_carryout", 32'(c0), 0);
        chk("midrst_overflow", 32'(o0), 0);
        chk("midrst_zero", 32'(z0), 0);
        rst_n = 1'b1;
        issue(0, 16'd200, 16'd95, 1'b0, 16'd39, 1'b1, 1'b0, 1'b0, 2);
        drain();

        issue(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4);
        issue(2, 16'd14,   16'd53,   1'b1, 16'd217,  1'b0, 1'b0, 1'b0, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time actual=%0t required<200000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor.
- Processes operands CHUNK bits per clock, least-significant chunk first, with the ripple carry held in a register between cycles.
- Uses valid/ready handshakes on both the operand side and the result side.
- Reports carry-out, signed overflow and zero flags.
- Next-generation replacement for the combinational 8-bit adder/subtractor in the datapath, used where width grows beyond single-cycle timing.

Parameters:
- WIDTH, 8, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per CALC cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of CALC cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands and mode present
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A−B
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference modulo 2^WIDTH
- carryout  output  1  carry out of MSB (for subtract: 1 = no borrow)
- overflow  output  1  signed overflow
- zero  output  1  result == 0

Behaviour:
- Reset:
  - rst_n is sampled only on a rising clk edge.
  - While low at an edge: state←IDLE; in_ready, out_valid, result, carryout, overflow, zero all ←0; internal operand, carry and counter registers ←0.
  - in_ready becomes 1 on the first edge with rst_n high.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1, latch a into the A register, latch (b XOR {WIDTH{sub}}) into the B register, carry←sub, chunk counter←0, state←CALC.
- CALC:
  - in_ready=0; a, b, sub and in_valid are ignored, so later input changes do not affect the operation in flight.
  - Each edge: {c, r} = A[k] + B[k] + carry, with CHUNK-bit chunk index k = counter. Write r into result chunk k, carry←c, counter←counter+1.
  - On the edge processing k=NCHUNK−1: state←DONE, out_valid←1, carryout←final carry, and the flags below are registered from the final result.
- Flags, registered together with out_valid:
  - overflow = (A[WIDTH−1] == B'[WIDTH−1]) && (result[WIDTH−1] != A[WIDTH−1]), where B' is the inverted B when sub=1.
  - zero = (result == 0).
- DONE:
  - out_valid=1; result and all flags are held stable.
  - in_ready=0.
  - On an edge with out_ready=1: state←IDLE, out_valid←0. result and flags keep their values until the next operation overwrites them.
- Latency and throughput:
  - out_valid is high after exactly NCHUNK edges following the accept edge.
  - Minimum issue interval is NCHUNK+2 cycles (accept edge, NCHUNK CALC edges, DONE handshake edge).
  - No accept occurs in the same cycle as the result handshake.
- Backpressure: out_ready low holds DONE indefinitely with outputs stable.
- Reset mid-operation (CALC or DONE): the operation is discarded and no out_valid is produced. Same reset values as above.
- CHUNK=WIDTH is legal: one CALC cycle.
- Arithmetic: result wraps modulo 2^WIDTH. Subtract uses A + ~B + 1.

Test Plan:
1. WIDTH=8, CHUNK=4; a=27, b=5, sub=0 → result=32, carryout=0, overflow=0, zero=0; out_valid rises 2 edges after accept.
2. a=16, b=34, sub=1 → result=238 (0xEE), carryout=0, overflow=0. Then a=196, b=2, sub=1 → result=194, carryout=1, overflow=0.
3. a=100, b=100, sub=0 → result=200, carryout=0, overflow=1. Then a=78, b=255, sub=0 → result=77, carryout=1, overflow=0. Then a=48, b=48, sub=1 → result=0, carryout=1, zero=1.
4. Backpressure: out_ready=0 for 5 cycles after out_valid → result and flags stable, in_ready=0. Also change a/b during CALC → result unaffected. Raise out_ready → out_valid low next edge, in_ready=1.
5. Reset: assert rst_n=0 for one edge during CALC → all outputs 0, no out_valid. The next operation (a=200, b=95, sub=0) → result=39, carryout=1, overflow=0.
6. WIDTH=16, CHUNK=4; a=0xFFFF, b=0x0001, sub=0 → result=0, carryout=1, zero=1, overflow=0, latency 4. Also WIDTH=8, CHUNK=8; a=14, b=53, sub=1 → result=217, carryout=0, latency 1.
